// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial path: frame layout, control codes,
// transmitter FSM states and the CRC3 used on result packets.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_TYPE,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CTL  = 1'b1;

    localparam int unsigned FRAME_LEN = 11;

    // Error/echo control codes (bit7 set) shared with the ALU core and deserializer
    localparam logic [7:0] CTL_ERR_DATA = 8'b1100_1001;
    localparam logic [7:0] CTL_ERR_CRC  = 8'b1010_0101;
    localparam logic [7:0] CTL_ERR_OP   = 8'b1001_0011;

    // CRC3, polynomial x^3+x+1, init 0, data consumed MSB first
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 37; i++) begin
            fb = c[2] ^ d[36 - i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result handshake between the ALU core (master) and the serializer (slave).
interface mtm_alu_serializer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] C;
    logic [7:0]  CTL;

    modport master (output in_valid, output C, output CTL, input in_ready);
    modport slave  (input in_valid, input C, input CTL, output in_ready);

endinterface

// File: rtl/mtm_alu_frame_tx.sv
// Sends one 11-bit frame {start, type, byte MSB first, stop}; a new frame may be
// loaded on the last stop-bit cycle so consecutive frames have no gap.
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_type,
    input  logic [7:0] i_byte,
    output logic       o_sout,
    output logic       o_idle,
    output logic       o_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

    tx_state_e  r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [7:0] r_byte;
    logic       r_type;
    logic       r_sout;
    logic       r_idle;

    logic w_tick;
    logic w_done;
    logic w_load;

    assign w_tick = (r_div == DIV_LAST);
    assign w_done = (r_state == TX_STOP) && w_tick;
    assign w_load = i_start && ((r_state == TX_IDLE) || w_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_type  <= 1'b0;
            r_sout  <= 1'b1;
            r_idle  <= 1'b1;
        end else if (w_load) begin
            r_state <= TX_START;
            r_div   <= '0;
            r_bit   <= 3'd7;
            r_byte  <= i_byte;
            r_type  <= i_type;
            r_sout  <= 1'b0;
            r_idle  <= 1'b0;
        end else if (r_state != TX_IDLE) begin
            if (!w_tick) begin
                r_div <= r_div + 8'd1;
            end else begin
                r_div <= '0;
                case (r_state)
                    TX_START: begin
                        r_state <= TX_TYPE;
                        r_sout  <= r_type;
                    end
                    TX_TYPE: begin
                        r_state <= TX_DATA;
                        r_bit   <= 3'd7;
                        r_sout  <= r_byte[7];
                    end
                    TX_DATA: begin
                        if (r_bit == 3'd0) begin
                            r_state <= TX_STOP;
                            r_sout  <= 1'b1;
                        end else begin
                            r_bit  <= r_bit - 3'd1;
                            r_sout <= r_byte[r_bit - 3'd1];
                        end
                    end
                    default: begin
                        r_state <= TX_IDLE;
                        r_sout  <= 1'b1;
                        r_idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_sout = r_sout;
    assign o_idle = r_idle;
    assign o_done = w_done;

endmodule

// File: rtl/mtm_alu_serializer.sv
// ALU result serializer: accepts C/CTL, emits 4 DATA + 1 CTL frames (or a lone
// CTL frame for error/echo codes) and optionally re-checks the result CRC3.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          CHECK_CRC    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_serializer_if.slave  bus,
    output logic                 sout,
    output logic                 busy,
    output logic                 crc_err
);

    logic [31:0] r_c;
    logic [7:0]  r_ctl;
    logic [2:0]  r_frame;
    logic        r_crc_err;

    logic       w_idle;
    logic       w_done;
    logic       w_sout;
    logic       w_accept;
    logic       w_next;
    logic       w_start;
    logic       w_type;
    logic [7:0] w_byte;

    assign w_accept = bus.in_valid && w_idle;
    assign w_next   = w_done && !r_ctl[7] && (r_frame <= 3'd4);

    // First frame is fed straight from the inputs so its start bit follows the accept edge
    always_comb begin
        w_start = 1'b0;
        w_type  = FRAME_DATA;
        w_byte  = '0;
        if (w_accept) begin
            w_start = 1'b1;
            if (bus.CTL[7]) begin
                w_type = FRAME_CTL;
                w_byte = bus.CTL;
            end else begin
                w_byte = bus.C[31:24];
            end
        end else if (w_next) begin
            w_start = 1'b1;
            case (r_frame)
                3'd1:    w_byte = r_c[23:16];
                3'd2:    w_byte = r_c[15:8];
                3'd3:    w_byte = r_c[7:0];
                default: begin
                    w_type = FRAME_CTL;
                    w_byte = r_ctl;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c       <= '0;
            r_ctl     <= '0;
            r_frame   <= '0;
            r_crc_err <= 1'b0;
        end else begin
            r_crc_err <= 1'b0;
            if (w_accept) begin
                r_c       <= bus.C;
                r_ctl     <= bus.CTL;
                r_frame   <= 3'd1;
                r_crc_err <= CHECK_CRC && !bus.CTL[7] &&
                             (crc3({bus.C, 1'b0, bus.CTL[6:3]}) != bus.CTL[2:0]);
            end else if (w_next) begin
                r_frame <= r_frame + 3'd1;
            end
        end
    end

    mtm_alu_frame_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame_tx (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_start),
        .i_type (w_type),
        .i_byte (w_byte),
        .o_sout (w_sout),
        .o_idle (w_idle),
        .o_done (w_done)
    );

    assign bus.in_ready = w_idle;
    assign busy         = !w_idle;
    assign sout         = w_sout;
    assign crc_err      = r_crc_err;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Bench for mtm_alu_serializer: two instances (1 and 4 clocks per bit) checked
// every cycle against a bit-queue model of the serial packet.
module tb_mtm_alu_serializer;
    import mtm_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtm_alu_serializer_if bus1();
    mtm_alu_serializer_if bus4();

    logic sout1, busy1, crc1;
    logic sout4, busy4, crc4;

    mtm_alu_serializer #(.CLKS_PER_BIT(1), .CHECK_CRC(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sout(sout1), .busy(busy1), .crc_err(crc1)
    );

    mtm_alu_serializer #(.CLKS_PER_BIT(4), .CHECK_CRC(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .sout(sout4), .busy(busy4), .crc_err(crc4)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: expected sout bits for the coming cycles; empty queue means idle
    bit q [2][$];
    bit exp_crc [2];
    int n_acc [2];

    function automatic int cpb(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // CRC as the remainder of (data * x^3) divided by x^3+x+1
    function automatic logic [2:0] ref_crc(logic [31:0] c, logic [3:0] flags);
        logic [39:0] r;
        r = {c, 1'b0, flags, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [7:0] good_ctl(logic [31:0] c, logic [3:0] flags);
        return {1'b0, flags, ref_crc(c, flags)};
    endfunction

    task automatic push_packet(int d, logic [31:0] c, logic [7:0] ctl);
        logic [7:0]  bytes [$];
        bit          types [$];
        logic [10:0] f;
        if (!ctl[7]) begin
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(c[31 - 8*k -: 8]);
                types.push_back(1'b0);
            end
        end
        bytes.push_back(ctl);
        types.push_back(1'b1);
        for (int i = 0; i < bytes.size(); i++) begin
            f = {1'b0, types[i], bytes[i], 1'b1};
            for (int b = int'(FRAME_LEN) - 1; b >= 0; b--)
                for (int r = 0; r < cpb(d); r++)
                    q[d].push_back(f[b]);
        end
    endtask

    task automatic model_step(int d, logic v, logic [31:0] c, logic [7:0] ctl);
        exp_crc[d] = 1'b0;
        if (rst) begin
            q[d].delete();
        end else if (q[d].size() == 0) begin
            if (v) begin
                push_packet(d, c, ctl);
                exp_crc[d] = !ctl[7] && (ref_crc(c, ctl[6:3]) != ctl[2:0]);
                n_acc[d]++;
            end
        end else begin
            void'(q[d].pop_front());
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(int d);
        logic s, r, b, e;
        bit   idle;
        if (d == 0) begin s = sout1; r = bus1.in_ready; b = busy1; e = crc1; end
        else        begin s = sout4; r = bus4.in_ready; b = busy4; e = crc4; end
        idle = (q[d].size() == 0);
        chk($sformatf("sout[%0d]", cpb(d)),     {31'b0, s}, {31'b0, idle ? 1'b1 : q[d][0]});
        chk($sformatf("in_ready[%0d]", cpb(d)), {31'b0, r}, {31'b0, idle});
        chk($sformatf("busy[%0d]", cpb(d)),     {31'b0, b}, {31'b0, !idle});
        chk($sformatf("crc_err[%0d]", cpb(d)),  {31'b0, e}, {31'b0, exp_crc[d]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, bus1.in_valid, bus1.C, bus1.CTL);
        model_step(1, bus4.in_valid, bus4.C, bus4.CTL);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic set1(logic v, logic [31:0] c, logic [7:0] ctl);
        bus1.in_valid = v; bus1.C = c; bus1.CTL = ctl;
    endtask

    task automatic set4(logic v, logic [31:0] c, logic [7:0] ctl);
        bus4.in_valid = v; bus4.C = c; bus4.CTL = ctl;
    endtask

    task automatic wait_idle(int d, int budget);
        int n = 0;
        while (q[d].size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (q[d].size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle[%0d]: still busy after %0d cycles", cpb(d), budget);
        end
    endtask

    // Collects the 11 sout samples of dut1 starting with the current cycle
    task automatic grab_frame1(output logic [10:0] f);
        for (int b = 10; b >= 0; b--) begin
            f[b] = sout1;
            if (b != 0) tick();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        logic [31:0] c;
        logic [7:0]  ctl;
        int          n;
        int          gap;

        n_acc[0] = 0;
        n_acc[1] = 0;
        set1(1'b0, '0, '0);
        set4(1'b0, '0, '0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Hand-computed remainders pin the reference CRC
        chk("pin_crc_zero", {29'b0, ref_crc(32'h0, 4'b0000)}, 32'd0);
        chk("pin_crc_x3",   {29'b0, ref_crc(32'h0, 4'b0001)}, 32'b011);
        chk("pin_crc_x4",   {29'b0, ref_crc(32'h0, 4'b0010)}, 32'b110);
        chk("pin_crc_x5",   {29'b0, ref_crc(32'h0, 4'b0100)}, 32'b111);
        chk("pin_crc_x8",   {29'b0, ref_crc(32'h1, 4'b0000)}, 32'b010);

        // All-zero result: 55-cycle packet, no CRC error
        set1(1'b1, 32'h0, 8'h00);
        tick();
        set1(1'b0, 32'h0, 8'h00);
        chk("t1_ready_drop", {31'b0, bus1.in_ready}, 32'd0);
        chk("t1_crc_ok", {31'b0, crc1}, 32'd0);
        n = 0;
        while (busy1 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("t1_busy_len", n, 32'd55);
        tick();

        // Patterned word: first frame carries A5 as DATA
        c = 32'hA5C3_0F81;
        set1(1'b1, c, good_ctl(c, 4'b1010));
        tick();
        set1(1'b0, 32'h0, 8'h00);
        grab_frame1(f);
        chk("t2_frame0", {21'b0, f}, {21'b0, 11'b0_0_1010_0101_1});
        wait_idle(0, 100);
        tick();

        // Bad CRC: one-cycle crc_err, packet still sent
        set1(1'b1, 32'h0, 8'h01);
        tick();
        set1(1'b0, 32'h0, 8'h00);
        chk("t3_crc_pulse", {31'b0, crc1}, 32'd1);
        tick();
        chk("t3_crc_clear", {31'b0, crc1}, 32'd0);
        wait_idle(0, 100);
        tick();

        // Error code: lone CTL frame
        set1(1'b1, 32'hDEAD_BEEF, CTL_ERR_OP);
        tick();
        set1(1'b0, 32'h0, 8'h00);
        grab_frame1(f);
        chk("t4_ctl_frame", {21'b0, f}, {21'b0, 11'b0_1_1001_0011_1});
        tick();
        chk("t4_ready_after", {31'b0, bus1.in_ready}, 32'd1);
        tick();

        // Reset mid-packet, then a clean packet
        c = 32'h1234_5678;
        set1(1'b1, c, good_ctl(c, 4'b0110));
        tick();
        set1(1'b0, 32'h0, 8'h00);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_sout_high", {31'b0, sout1}, 32'd1);
        chk("t5_ready", {31'b0, bus1.in_ready}, 32'd1);
        chk("t5_busy_low", {31'b0, busy1}, 32'd0);
        c = 32'h8765_4321;
        set1(1'b1, c, good_ctl(c, 4'b0011));
        tick();
        set1(1'b0, 32'h0, 8'h00);
        wait_idle(0, 100);

        // Four clocks per bit, in_valid held for two back-to-back results
        c = 32'hCAFE_F00D;
        set4(1'b1, c, good_ctl(c, 4'b1001));
        n = 0;
        while (n_acc[1] < 1 && n < 10) begin tick(); n++; end
        c = 32'h0BAD_1DEA;
        set4(1'b1, c, good_ctl(c, 4'b0101));
        gap = 0;
        n = 0;
        while (n_acc[1] < 2 && n < 500) begin
            tick();
            n++;
            if (bus4.in_ready === 1'b1) gap++;
        end
        set4(1'b0, 32'h0, 8'h00);
        chk("t6_second_accepted", n_acc[1], 32'd2);
        chk("t6_idle_gap", gap, 32'd1);
        wait_idle(1, 400);
        tick();

        // Random traffic on both instances with occasional resets
        for (int i = 0; i < 4000; i++) begin
            for (int d = 0; d < 2; d++) begin
                logic v;
                int   mode;
                v    = ($urandom_range(0, 3) != 0);
                c    = $urandom;
                mode = $urandom_range(0, 2);
                if (mode == 0)      ctl = good_ctl(c, 4'($urandom));
                else if (mode == 1) ctl = {1'b0, 7'($urandom)};
                else begin
                    case ($urandom_range(0, 2))
                        0:       ctl = CTL_ERR_DATA;
                        1:       ctl = CTL_ERR_CRC;
                        default: ctl = CTL_ERR_OP;
                    endcase
                end
                if (d == 0) set1(v, c, ctl);
                else        set4(v, c, ctl);
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        set1(1'b0, 32'h0, 8'h00);
        set4(1'b0, 32'h0, 8'h00);
        wait_idle(0, 100);
        wait_idle(1, 400);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
